// File: rtl/sort_seq_pkg.sv
// Shared types and constants for the sequential bubble sorter.
package sort_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sort_seq_if.sv
// Start/busy/done handshake and word buses of the sorter.
interface sort_seq_if
  import sort_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = 4
) ();

  localparam int CNT_W = clog2(N * (N - 1) / 2 + 1);

  logic                 start;
  logic                 ascending;
  logic [N*WIDTH-1:0]   din;
  logic                 busy;
  logic                 done;
  logic [N*WIDTH-1:0]   dout;
  logic [CNT_W-1:0]     swap_cnt;

  modport master (output start, ascending, din, input busy, done, dout, swap_cnt);
  modport slave  (input start, ascending, din, output busy, done, dout, swap_cnt);

endinterface

// File: rtl/sort_seq_mag_cmp.sv
// Unsigned magnitude comparator; exactly one of g/e/l is high.
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             g,
  output logic             e,
  output logic             l
);

  assign g = (a > b);
  assign e = (a == b);
  assign l = (a < b);

endmodule

// File: rtl/sort_seq.sv
// Sequential stable bubble sort of N words, one compare-and-swap per cycle through
// a single shared comparator; start/busy/done handshake, exits early on a clean pass.
module sort_seq
  import sort_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = 4
) (
  input  logic     clk,
  input  logic     rst,
  sort_seq_if.slave bus
);

  localparam int IW    = clog2(N);
  localparam int PW    = clog2(N);
  localparam int CNT_W = clog2(N * (N - 1) / 2 + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 2);
  localparam logic [PW-1:0] LAST_PASS = PW'(N - 2);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     w_q [N];
  logic [WIDTH-1:0]     w_d [N];
  logic [IW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        pass_q, pass_d;
  logic                 swapped_q, swapped_d;
  logic                 asc_q, asc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N*WIDTH-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]     swap_cnt_q, swap_cnt_d;

  logic [IW-1:0]        idx_p1;
  logic [WIDTH-1:0]     cmp_a, cmp_b;
  logic                 cmp_g, cmp_e, cmp_l;
  logic                 do_swap;
  logic                 end_sort;
  logic [N*WIDTH-1:0]   w_flat;

  assign idx_p1 = idx_q + IW'(1);
  assign cmp_a  = w_q[idx_q];
  assign cmp_b  = w_q[idx_p1];

  mag_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a (cmp_a),
    .b (cmp_b),
    .g (cmp_g),
    .e (cmp_e),
    .l (cmp_l)
  );

  // Strict inequality only, so equal words keep their order.
  assign do_swap  = asc_q ? cmp_g : cmp_l;
  assign end_sort = (idx_q == LAST_IDX) &&
                    (!(swapped_q || do_swap) || (pass_q == LAST_PASS));

  always_comb begin
    w_flat = '0;
    for (int k = 0; k < N; k++) w_flat[k*WIDTH +: WIDTH] = w_q[k];
  end

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      for (int k = 0; k < N; k++) w_q[k] <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      swapped_q  <= 1'b0;
      asc_q      <= 1'b0;
      cnt_q      <= '0;
      dout_q     <= '0;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      for (int k = 0; k < N; k++) w_q[k] <= w_d[k];
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      swapped_q  <= swapped_d;
      asc_q      <= asc_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_SORT;
      ST_SORT: if (end_sort)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    for (int k = 0; k < N; k++) w_d[k] = w_q[k];
    idx_d      = idx_q;
    pass_d     = pass_q;
    swapped_d  = swapped_q;
    asc_d      = asc_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    swap_cnt_d = swap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          for (int k = 0; k < N; k++) w_d[k] = bus.din[k*WIDTH +: WIDTH];
          asc_d     = bus.ascending;
          idx_d     = '0;
          pass_d    = '0;
          swapped_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_SORT: begin
        if (do_swap) begin
          w_d[idx_q]  = cmp_b;
          w_d[idx_p1] = cmp_a;
          swapped_d   = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
        end
        if (idx_q != LAST_IDX) begin
          idx_d = idx_p1;
        end else if (!end_sort) begin
          idx_d     = '0;
          pass_d    = pass_q + PW'(1);
          swapped_d = 1'b0;
        end
      end
      ST_DONE: begin
        dout_d     = w_flat;
        swap_cnt_d = cnt_q;
      end
      default: ;
    endcase
  end

  // Outputs; the DONE cycle shows the fresh result before it lands in the hold regs
  always_comb begin
    bus.busy     = (state_q != ST_IDLE);
    bus.done     = (state_q == ST_DONE);
    bus.dout     = (state_q == ST_DONE) ? w_flat : dout_q;
    bus.swap_cnt = (state_q == ST_DONE) ? cnt_q  : swap_cnt_q;
  end

endmodule
